// File: rtl/mii_pkg.sv
// Shared MII definitions.
// Holds the receive FSM state type, the CRC-32 constants and the per-byte CRC update
// that the receive deframer and the transmit FCS generator both use.
package mii_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPreamble,
    StData,
    StDrop
  } rx_state_e;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  // Good-frame residue in MSB-first notation.
  localparam logic [31:0] CRC32_RESIDUE   = 32'hC704DD7B;

  // Reflected CRC-32 update of one byte. Bits are processed LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/mii_rx_deframer_if.sv
// Bundles the PHY-side receive inputs and the byte-stream/statistics outputs.
//   PHY_RX, RX_DV          : MII nibble stream from the PHY
//   rx_data/valid/sop/eop  : payload byte stream with frame markers
//   rx_err                 : frame status, meaningful with rx_eop
//   frames_ok, frames_bad  : saturating frame counters
// master = deframer side, slave = consumer/stimulus side.
interface mii_rx_deframer_if;
  logic [3:0]  PHY_RX;
  logic        RX_DV;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_sop;
  logic        rx_eop;
  logic        rx_err;
  logic [15:0] frames_ok;
  logic [15:0] frames_bad;

  modport master (
    input  PHY_RX, RX_DV,
    output rx_data, rx_valid, rx_sop, rx_eop, rx_err, frames_ok, frames_bad
  );

  modport slave (
    output PHY_RX, RX_DV,
    input  rx_data, rx_valid, rx_sop, rx_eop, rx_err, frames_ok, frames_bad
  );
endinterface

// File: rtl/mii_rx_delay5.sv
// Five-entry byte delay line used to hold back the trailing FCS bytes.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_clear      : empty the line (start of frame)
//   i_push       : shift i_data in
//   o_full       : five bytes held
//   o_head       : oldest byte, valid when o_full
module mii_rx_delay5 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clear,
  input  logic       i_push,
  input  logic [7:0] i_data,
  output logic       o_full,
  output logic [7:0] o_head
);

  logic [7:0] r_mem [5];
  logic [2:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
      for (int i = 0; i < 5; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_push) begin
      r_mem[0] <= i_data;
      for (int i = 1; i < 5; i++) begin
        r_mem[i] <= r_mem[i-1];
      end
      if (r_count != 3'd5) begin
        r_count <= r_count + 3'd1;
      end
    end
  end

  assign o_full = (r_count == 3'd5);
  assign o_head = r_mem[4];

endmodule

// File: rtl/mii_rx_deframer.sv
// MII receive deframer: strips preamble/SFD, assembles bytes from nibbles, checks the
// CRC-32 FCS and emits payload bytes (FCS removed) with sop/eop/err markers.
//   PHY_RX_CLOCK : MII receive clock, the only clock
//   rx_reset     : synchronous active-high reset
//   bus          : PHY nibble inputs, byte stream outputs and frame counters
module mii_rx_deframer
  import mii_pkg::*;
#(
  parameter int unsigned MAX_LEN = 1518,
  parameter int unsigned MIN_LEN = 64
) (
  input  logic              PHY_RX_CLOCK,
  input  logic              rx_reset,
  mii_rx_deframer_if.master bus
);

  localparam logic [10:0] MaxLenW = 11'(MAX_LEN);
  localparam logic [10:0] MinLenW = 11'(MIN_LEN);

  rx_state_e   r_state, w_state_next;
  logic        r_phase;
  logic [3:0]  r_low;
  logic [10:0] r_byte_cnt;
  logic [31:0] r_crc;
  logic        r_sop_pend;
  logic [7:0]  r_data;
  logic        r_valid, r_sop, r_eop, r_err;
  logic [15:0] r_ok, r_bad;

  logic        w_push, w_clear, w_eof, w_full, w_frame_bad;
  logic [7:0]  w_byte, w_head;
  logic [31:0] w_crc_next;

  assign w_byte     = {bus.PHY_RX, r_low};
  assign w_crc_next = crc32_byte(r_crc, w_byte);

  // The register is reflected, so compare against the bit-reversed residue.
  assign w_frame_bad = r_phase || (r_crc != bitrev32(CRC32_RESIDUE)) ||
                       (r_byte_cnt < MinLenW) || (r_byte_cnt > MaxLenW);

  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_clear      = 1'b0;
    w_eof        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.RX_DV) begin
          w_state_next = (bus.PHY_RX == 4'h5) ? StPreamble : StDrop;
        end
      end
      StPreamble: begin
        if (!bus.RX_DV) begin
          w_state_next = StIdle;
        end else if (bus.PHY_RX == 4'hD) begin
          w_state_next = StData;
          w_clear      = 1'b1;
        end else if (bus.PHY_RX != 4'h5) begin
          w_state_next = StDrop;
        end
      end
      StData: begin
        if (!bus.RX_DV) begin
          w_eof        = 1'b1;
          w_state_next = StIdle;
        end else begin
          w_push = r_phase;
        end
      end
      StDrop: begin
        if (!bus.RX_DV) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StDrop;
    endcase
  end

  mii_rx_delay5 u_delay (
    .i_clk   (PHY_RX_CLOCK),
    .i_rst   (rx_reset),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_data  (w_byte),
    .o_full  (w_full),
    .o_head  (w_head)
  );

  always_ff @(posedge PHY_RX_CLOCK) begin
    if (rx_reset) begin
      r_state    <= StDrop;
      r_phase    <= 1'b0;
      r_low      <= '0;
      r_byte_cnt <= '0;
      r_crc      <= '1;
      r_sop_pend <= 1'b0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_sop      <= 1'b0;
      r_eop      <= 1'b0;
      r_err      <= 1'b0;
      r_ok       <= '0;
      r_bad      <= '0;
    end else begin
      r_state <= w_state_next;
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_err   <= 1'b0;

      if (w_clear) begin
        r_phase    <= 1'b0;
        r_byte_cnt <= '0;
        r_crc      <= '1;
        r_sop_pend <= 1'b1;
      end

      if (r_state == StData && bus.RX_DV) begin
        r_phase <= ~r_phase;
        if (!r_phase) begin
          r_low <= bus.PHY_RX;
        end
      end

      if (w_push) begin
        r_crc <= w_crc_next;
        if (r_byte_cnt != 11'd2047) begin
          r_byte_cnt <= r_byte_cnt + 11'd1;
        end
        // A full line means the oldest byte can no longer be FCS.
        if (w_full) begin
          r_valid    <= 1'b1;
          r_data     <= w_head;
          r_sop      <= r_sop_pend;
          r_sop_pend <= 1'b0;
        end
      end

      if (w_eof) begin
        if (w_frame_bad) begin
          if (r_bad != 16'hFFFF) r_bad <= r_bad + 16'd1;
        end else begin
          if (r_ok != 16'hFFFF) r_ok <= r_ok + 16'd1;
        end
        if (w_full) begin
          r_valid    <= 1'b1;
          r_data     <= w_head;
          r_sop      <= r_sop_pend;
          r_eop      <= 1'b1;
          r_err      <= w_frame_bad;
          r_sop_pend <= 1'b0;
        end
      end
    end
  end

  assign bus.rx_data    = r_data;
  assign bus.rx_valid   = r_valid;
  assign bus.rx_sop     = r_sop;
  assign bus.rx_eop     = r_eop;
  assign bus.rx_err     = r_err;
  assign bus.frames_ok  = r_ok;
  assign bus.frames_bad = r_bad;

endmodule

// File: tb/tb_mii_rx_deframer.sv
// Bench for mii_rx_deframer: directed frames, expected bytes queued at stimulus time,
// a negedge monitor pops and compares every emitted byte.
module tb_mii_rx_deframer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mii_rx_deframer_if bus ();

  mii_rx_deframer #(
    .MAX_LEN (1518),
    .MIN_LEN (64)
  ) dut (
    .PHY_RX_CLOCK (clk),
    .rx_reset     (rst),
    .bus          (bus)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic       err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [7:0]  fb[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_ok  = '0;
  logic [15:0] exp_bad = '0;

  // Bit-serial reference CRC, independent of the byte-wise form in the design.
  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] b);
    logic f;
    for (int i = 0; i < 8; i++) begin
      f = c[0] ^ b[i];
      c = {1'b0, c[31:1]};
      if (f) c = c ^ 32'hEDB88320;
    end
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Payload of n bytes counting up from first, then FCS (complemented CRC, LSB first).
  task automatic make_frame(input int n, input logic [7:0] first, input bit flip);
    logic [31:0] crc;
    logic [7:0]  b;
    fb.delete();
    crc = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      b = 8'(first + 8'(i));
      fb.push_back(b);
      crc = ref_crc(crc, b);
    end
    crc = ~crc;
    for (int i = 0; i < 4; i++) fb.push_back(crc[8*i +: 8]);
    if (flip) begin
      b = fb[fb.size()-1] ^ 8'h01;
      fb[fb.size()-1] = b;
    end
  endtask

  task automatic expect_frame(input bit err);
    exp_t e;
    int   n;
    n = fb.size();
    for (int i = 0; i + 4 < n; i++) begin
      e.data = fb[i];
      e.sop  = (i == 0);
      e.eop  = (i == n - 5);
      e.err  = (i == n - 5) && err;
      exp_q.push_back(e);
    end
    if (err) exp_bad++;
    else     exp_ok++;
  endtask

  task automatic drive(input logic dv, input logic [3:0] nib);
    bus.RX_DV  = dv;
    bus.PHY_RX = nib;
    @(posedge clk);
    #1;
  endtask

  task automatic send_preamble();
    for (int i = 0; i < 15; i++) drive(1'b1, 4'h5);
    drive(1'b1, 4'hD);
  endtask

  task automatic send_bytes(input int from);
    for (int i = from; i < fb.size(); i++) begin
      drive(1'b1, fb[i][3:0]);
      drive(1'b1, fb[i][7:4]);
    end
  endtask

  task automatic send_frame(input bit dribble);
    send_preamble();
    send_bytes(0);
    if (dribble) drive(1'b1, 4'hA);
    drive(1'b0, 4'h0);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_frames_ok"}, 32'(bus.frames_ok), 32'(exp_ok));
    check({tag, "_frames_bad"}, 32'(bus.frames_bad), 32'(exp_bad));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rx_valid"}, 32'(bus.rx_valid), 32'd0);
    check({tag, "_rx_data"}, 32'(bus.rx_data), 32'd0);
    check({tag, "_rx_sop"}, 32'(bus.rx_sop), 32'd0);
    check({tag, "_rx_eop"}, 32'(bus.rx_eop), 32'd0);
    check({tag, "_rx_err"}, 32'(bus.rx_err), 32'd0);
    check_counters(tag);
  endtask

  // Monitor: marker sanity every cycle, scoreboard compare on each strobe.
  always @(negedge clk) begin
    if (!rst) begin
      total++;
      if ((!bus.rx_valid && (bus.rx_sop || bus.rx_eop)) || (bus.rx_err && !bus.rx_eop)) begin
        bad++;
        $display("FAIL markers actual valid=%0b sop=%0b eop=%0b err=%0b required no stray marker",
                 bus.rx_valid, bus.rx_sop, bus.rx_eop, bus.rx_err);
      end
      if (bus.rx_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_byte actual data=%0h required no rx_valid", bus.rx_data);
        end else begin
          mon_e = exp_q.pop_front();
          if ({bus.rx_data, bus.rx_sop, bus.rx_eop, bus.rx_err} !== mon_e) begin
            bad++;
            $display("FAIL byte actual data=%0h sop=%0b eop=%0b err=%0b required data=%0h sop=%0b eop=%0b err=%0b",
                     bus.rx_data, bus.rx_sop, bus.rx_eop, bus.rx_err,
                     mon_e.data, mon_e.sop, mon_e.eop, mon_e.err);
          end
        end
      end
    end
  end

  initial begin
    rst        = 1'b1;
    bus.RX_DV  = 1'b0;
    bus.PHY_RX = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst = 1'b0;
    drive(1'b0, 4'h0);

    // Good minimum-length frame, payload 0x00..0x3B.
    make_frame(60, 8'h00, 1'b0);
    expect_frame(1'b0);
    send_frame(1'b0);
    check_counters("good");

    // Same frame, last FCS byte corrupted.
    make_frame(60, 8'h00, 1'b1);
    expect_frame(1'b1);
    send_frame(1'b0);
    check_counters("bad_fcs");

    // Runt: 20 bytes including FCS.
    make_frame(16, 8'hA0, 1'b0);
    expect_frame(1'b1);
    send_frame(1'b0);
    check_counters("runt");

    // One byte short of minimum.
    make_frame(59, 8'h10, 1'b0);
    expect_frame(1'b1);
    send_frame(1'b0);
    check_counters("len63");

    // Dribble nibble after a good 64-byte frame.
    make_frame(60, 8'h40, 1'b0);
    expect_frame(1'b1);
    send_frame(1'b1);
    check_counters("dribble");

    // Maximum length is accepted, one more byte is not.
    make_frame(1514, 8'h00, 1'b0);
    expect_frame(1'b0);
    send_frame(1'b0);
    check_counters("len1518");
    make_frame(1515, 8'h00, 1'b0);
    expect_frame(1'b1);
    send_frame(1'b0);
    check_counters("len1519");

    // Bad preamble: whole frame dropped, then a good frame after a 1-cycle gap.
    make_frame(60, 8'h20, 1'b0);
    drive(1'b1, 4'h5);
    drive(1'b1, 4'h5);
    drive(1'b1, 4'h3);
    send_preamble();
    send_bytes(0);
    drive(1'b0, 4'h0);
    check_counters("bad_pre");
    make_frame(60, 8'h80, 1'b0);
    expect_frame(1'b0);
    send_frame(1'b0);
    check_counters("after_bad_pre");

    // Reset mid-payload with RX_DV held high.
    make_frame(60, 8'hC0, 1'b0);
    send_preamble();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, fb[i][3:0]);
      drive(1'b1, fb[i][7:4]);
    end
    rst = 1'b1;
    drive(1'b1, fb[3][3:0]);
    rst     = 1'b0;
    exp_ok  = '0;
    exp_bad = '0;
    check_outputs_zero("mid_reset");
    drive(1'b1, fb[3][7:4]);
    send_bytes(4);
    drive(1'b0, 4'h0);
    check_counters("reset_drop");
    make_frame(60, 8'h33, 1'b0);
    expect_frame(1'b0);
    send_frame(1'b0);
    check_counters("after_reset");

    repeat (5) drive(1'b0, 4'h0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
